// File: rtl/pam_rx_pkg.sv
// Shared definitions for the PAM frame receiver: FSM state encoding and default sizing.
package pam_rx_pkg;

    localparam int unsigned DATA_LENGTH_DEF  = 24;
    localparam int unsigned TIMEOUT_CLKS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_DONE      = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } rx_state_e;

endpackage

// File: rtl/pam_rx_edge.sv
// Input conditioning for the PAM frame receiver: optional 2-flop synchronizer
// (PAM_RX_SYNC_INPUTS_EN), delayed copies and fall/rise strobes for bclk and nsync.
module pam_rx_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bclk_i,
    input  logic nsync_i,
    input  logic sdata_i,
    output logic bclk_fall_o,
    output logic nsync_fall_o,
    output logic nsync_rise_o,
    output logic nsync_o,
    output logic sdata_o
);

    logic bclk_s;
    logic nsync_s;
    logic sdata_s;

`ifdef PAM_RX_SYNC_INPUTS_EN
    logic [1:0] bclk_sync_q;
    logic [1:0] nsync_sync_q;
    logic [1:0] sdata_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bclk_sync_q  <= '0;
            nsync_sync_q <= '0;
            sdata_sync_q <= '0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[0], bclk_i};
            nsync_sync_q <= {nsync_sync_q[0], nsync_i};
            sdata_sync_q <= {sdata_sync_q[0], sdata_i};
        end
    end

    assign bclk_s  = bclk_sync_q[1];
    assign nsync_s = nsync_sync_q[1];
    assign sdata_s = sdata_sync_q[1];
`else
    assign bclk_s  = bclk_i;
    assign nsync_s = nsync_i;
    assign sdata_s = sdata_i;
`endif

    // Delayed copies reset low so an nsync held low through reset release never looks like a fall.
    logic bclk_prev_q;
    logic nsync_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bclk_prev_q  <= 1'b0;
            nsync_prev_q <= 1'b0;
        end else begin
            bclk_prev_q  <= bclk_s;
            nsync_prev_q <= nsync_s;
        end
    end

    assign bclk_fall_o  = bclk_prev_q & ~bclk_s;
    assign nsync_fall_o = nsync_prev_q & ~nsync_s;
    assign nsync_rise_o = ~nsync_prev_q & nsync_s;
    assign nsync_o      = nsync_s;
    assign sdata_o      = sdata_s;

endmodule

// File: rtl/pam_frame_receiver.sv
// Serial frame receiver (nsync/bclk/sdata -> parallel word) with short/long/stall detection.
// Define PAM_RX_SYNC_INPUTS_EN to add 2-flop input synchronizers for asynchronous sources.
//
//   state        | meaning
//   ST_IDLE      | waiting for an nsync fall
//   ST_SHIFT     | capturing bits on bclk falls, watching for nsync rise or stall
//   ST_DONE      | one-cycle settle after a frame end; a new nsync fall is taken here too
//   ST_WAIT_HIGH | frame aborted by stall, waiting for nsync high
module pam_frame_receiver
    import pam_rx_pkg::*;
#(
    parameter int unsigned DATA_LENGTH  = DATA_LENGTH_DEF,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   nsync_i,
    input  logic                   bclk_i,
    input  logic                   sdata_i,
    output logic [DATA_LENGTH-1:0] data_o,
    output logic                   valid_o,
    output logic                   frame_err_o,
    output logic                   busy_o
);

    localparam int unsigned BCNT_W = $clog2(DATA_LENGTH + 2);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(DATA_LENGTH);
    localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(DATA_LENGTH + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);

    logic bclk_fall;
    logic nsync_fall;
    logic nsync_rise;
    logic nsync_s;
    logic sdata_s;

    pam_rx_edge u_edge (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bclk_i       (bclk_i),
        .nsync_i      (nsync_i),
        .sdata_i      (sdata_i),
        .bclk_fall_o  (bclk_fall),
        .nsync_fall_o (nsync_fall),
        .nsync_rise_o (nsync_rise),
        .nsync_o      (nsync_s),
        .sdata_o      (sdata_s)
    );

    rx_state_e              state_q;
    logic [DATA_LENGTH-1:0] shift_q;
    logic [BCNT_W-1:0]      bcnt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [DATA_LENGTH-1:0] data_q;
    logic                   valid_q;
    logic                   err_q;

    logic [DATA_LENGTH-1:0] shift_d;
    logic [BCNT_W-1:0]      bcnt_d;
    logic [TMO_W-1:0]       tmo_d;

    // Saturating bit count keeps long frames distinguishable from exact-length ones.
    always_comb begin
        shift_d = {shift_q[DATA_LENGTH-2:0], sdata_s};
        bcnt_d  = (bcnt_q == BCNT_SAT) ? bcnt_q : bcnt_q + 1'b1;
        tmo_d   = tmo_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!enable_i) begin
                state_q <= ST_IDLE;
                bcnt_q  <= '0;
                tmo_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (nsync_fall) begin
                            state_q <= ST_SHIFT;
                            tmo_q   <= '0;
                            if (bclk_fall) begin
                                shift_q <= {{(DATA_LENGTH-1){1'b0}}, sdata_s};
                                bcnt_q  <= BCNT_W'(1);
                            end else begin
                                shift_q <= '0;
                                bcnt_q  <= '0;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_SHIFT: begin
                        // Frame verdict is registered on the exit edge so the strobe lines up with DONE.
                        if (nsync_rise) begin
                            state_q <= ST_DONE;
                            if (bcnt_q == BCNT_FULL) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (bclk_fall && !nsync_s) begin
                            shift_q <= shift_d;
                            bcnt_q  <= bcnt_d;
                            tmo_q   <= '0;
                        end else if (tmo_d == TMO_LIMIT) begin
                            tmo_q   <= tmo_d;
                            err_q   <= 1'b1;
                            state_q <= ST_WAIT_HIGH;
                        end else begin
                            tmo_q <= tmo_d;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (nsync_s) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pam_frame_receiver.sv
// Scoreboard bench for pam_frame_receiver: frame outcomes predicted from bit counts, checked by a monitor.
module tb_pam_frame_receiver;

    localparam int DL  = 24;
    localparam int TMO = 64;
`ifdef PAM_RX_SYNC_INPUTS_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic          nsync  = 1'b1;
    logic          bclk   = 1'b1;
    logic          sdata  = 1'b0;
    logic [DL-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    int cyc       = 0;
    int n_cmp     = 0;
    int n_bad     = 0;
    int last_fall = 0;

    typedef struct {
        bit            is_err;
        logic [DL-1:0] word;
        int            at;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    logic [DL-1:0] last_good = '0;

    pam_frame_receiver #(.DATA_LENGTH(DL), .TIMEOUT_CLKS(TMO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .nsync_i     (nsync),
        .bclk_i      (bclk),
        .sdata_i     (sdata),
        .data_o      (data),
        .valid_o     (valid),
        .frame_err_o (frame_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted frame outcome.
    always @(negedge clk) begin
        if (rst_n && (valid === 1'b1 || frame_err === 1'b1)) begin
            check("exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b at cycle %0d, none expected",
                         valid, frame_err, cyc);
            end else begin
                mon_e = q.pop_front();
                check("kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                check("cycle", cyc, mon_e.at);
                if (mon_e.is_err) begin
                    check("data_kept", {8'd0, data}, {8'd0, last_good});
                end else begin
                    check("data", {8'd0, data}, {8'd0, mon_e.word});
                    last_good = mon_e.word;
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit is_err, input logic [DL-1:0] word, input int at);
        exp_t e;
        e.is_err = is_err;
        e.word   = word;
        e.at     = at;
        q.push_back(e);
    endtask

    task automatic bits(input logic [31:0] w, input int n, input int h);
        for (int i = n - 1; i >= 0; i--) begin
            sdata = w[i];
            bclk  = 1'b1;
            hold(h);
            bclk      = 1'b0;
            last_fall = cyc;
            hold(h);
        end
    endtask

    // Reference rule: exactly DL bits gives the last DL bits as the word, anything else is an error.
    task automatic frame(input logic [31:0] w, input int n, input int h, input int gap);
        nsync = 1'b0;
        hold(h);
        bits(w, n, h);
        bclk = 1'b1;
        hold(1);
        nsync = 1'b1;
        push_exp(n != DL, w[DL-1:0], cyc + 1 + EXTRA);
        hold(gap);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d outcomes still pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          n;
        @(negedge clk);
        hold(3);
        check("rst_data", {8'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        hold(3);
        check("idle_busy", {31'd0, busy}, 32'd0);

        frame(32'hA5C3F0, 24, 6, 4);

        frame(32'h123456, 24, 3, 3);
        frame($urandom, 23, 3, 3);
        frame($urandom, 25, 3, 3);

        // Stall after 5 bits: error 65 cycles after the last fall, then held busy until nsync high.
        nsync = 1'b0;
        hold(2);
        bits($urandom, 5, 4);
        push_exp(1'b1, '0, last_fall + 1 + TMO + EXTRA);
        hold(TMO + 20);
        check("wait_high_busy", {31'd0, busy}, 32'd1);
        nsync = 1'b1;
        hold(3 + EXTRA);
        check("after_wait_busy", {31'd0, busy}, 32'd0);
        frame(32'h5A5A5A, 24, 3, 3);

        // Reset mid-frame: remainder of the frame must be ignored.
        w     = 32'h00C0FFEE;
        nsync = 1'b0;
        hold(2);
        bits(w >> 14, 10, 3);
        rst_n = 1'b0;
        hold(1);
        check("midrst_data", {8'd0, data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        last_good = '0;
        hold(1);
        rst_n = 1'b1;
        bits(w, 14, 3);
        bclk = 1'b1;
        hold(1);
        nsync = 1'b1;
        hold(4);
        frame(32'h000001, 24, 3, 3);

        frame(32'hFFFFFF, 24, 2, 1);
        frame(32'h000000, 24, 2, 3);

        // Enable dropped mid-frame, restored while nsync is still low.
        nsync = 1'b0;
        hold(2);
        bits(32'h3C3C3C >> 14, 10, 3);
        enable = 1'b0;
        hold(3);
        check("disabled_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        bits(32'h3C3C3C, 14, 3);
        bclk = 1'b1;
        hold(1);
        nsync = 1'b1;
        hold(4);
        frame(32'h0F1E2D, 24, 3, 3);

        // nsync fall and the first bclk fall in the same cycle: that bit is bit 0 of the frame.
        w     = 32'h00B00B1E;
        nsync = 1'b0;
        bclk  = 1'b0;
        sdata = w[23];
        hold(3);
        bclk = 1'b1;
        hold(3);
        bits(w, 23, 3);
        bclk = 1'b1;
        hold(1);
        nsync = 1'b1;
        push_exp(1'b0, w[DL-1:0], cyc + 1 + EXTRA);
        hold(4);

        // bclk fall coinciding with nsync rise is not a 25th bit.
        w     = 32'h00E1D2C3;
        nsync = 1'b0;
        hold(3);
        bits(w, 24, 3);
        bclk  = 1'b1;
        sdata = ~sdata;
        hold(3);
        bclk  = 1'b0;
        nsync = 1'b1;
        push_exp(1'b0, w[DL-1:0], cyc + 1 + EXTRA);
        hold(4);
        bclk = 1'b1;
        hold(2);

        for (int k = 0; k < 20; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 27)) : DL;
            frame($urandom, n, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
        end

        hold(20);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pam_frame_receiver.md
# pam_frame_receiver

Serial frame receiver for the PAM modulator's DAC-side output stream. It consumes the `nsync`/`bclk`/`sdata` triple, reconstructs each `DATA_LENGTH`-bit word (MSB first), and presents it as a parallel word with a one-cycle valid strobe. It flags malformed frames: short, long, or stalled. It serves as the downstream loopback/check stage, and as the receive half of a board-to-board link.

## Interface
- `DATA_LENGTH`, 24: bits per frame, MSB first.
- `TIMEOUT_CLKS`, 64: max `clk` cycles between consecutive `bclk` falling edges inside a frame.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `enable`  input  1  receiver enable.
- `nsync`  input  1  frame strobe, active low for the whole frame.
- `bclk`  input  1  bit clock; data stable at its falling edge.
- `sdata`  input  1  serial data.
- `data`  output  `DATA_LENGTH`  last good word.
- `valid`  output  1  one-cycle strobe when `data` is updated.
- `frame_err`  output  1  one-cycle strobe on a malformed or aborted frame.
- `busy`  output  1  high while the FSM is not in IDLE.

## Operation
- Edge detect compares the sampled `bclk`/`nsync` against a one-cycle-delayed copy:
  - `bclk` fall = prev 1, cur 0.
  - `nsync` fall/rise are defined the same way.
- FSM states:
  - IDLE: wait for `nsync` fall, then clear the shift register, bit counter and timeout counter, and go to SHIFT.
  - SHIFT: on each `bclk` fall with sampled `nsync`=0, shift `sdata` into the LSB, increment the bit counter, and clear the timeout counter. Otherwise increment the timeout counter.
  - SHIFT exits:
    - `nsync` rise: go to DONE.
    - Timeout counter reaching `TIMEOUT_CLKS`: pulse `frame_err`, go to WAIT_HIGH.
  - DONE (one cycle):
    - Bit count == `DATA_LENGTH`: load `data`, pulse `valid`.
    - Otherwise: pulse `frame_err`, leave `data` unchanged.
    - Then go to IDLE.
  - WAIT_HIGH: wait for sampled `nsync`=1, then go to IDLE. No `bclk` edges are captured here.
- Bit counter is `$clog2(DATA_LENGTH+2)` wide and saturates at `DATA_LENGTH+1`. Any long frame therefore yields `frame_err`. The shift register keeps only the last `DATA_LENGTH` bits.
- `nsync` fall and `bclk` fall in the same cycle while in IDLE: that bit is captured as bit 0.
- `nsync` rise and `bclk` fall in the same cycle: the bit is not captured.
- `enable`=0: FSM forced to IDLE and in-progress frame discarded, with no `valid`/`frame_err` pulse. Edge-detect registers keep tracking.
- Reset mid-frame: async clear. After release, IDLE needs a fresh `nsync` fall, so the remaining bits of the interrupted frame are ignored.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, all counters 0.
- Latency: `valid`/`frame_err` (short or long frame) is high in the cycle after the cycle in which the `nsync` rise is detected.
- Timeout `frame_err` is high in the cycle after the counter reaches `TIMEOUT_CLKS`.
- `valid` and `frame_err` are never high together; each is exactly one cycle wide.
- Back-to-back frames are accepted if `nsync` stays high for at least 1 sampled cycle; DONE→IDLE then catches the next fall.

## Configuration
- `PAM_RX_SYNC_INPUTS_EN` defined: `bclk`, `nsync` and `sdata` each pass through a 2-flop synchronizer before edge detect. All input-referenced latencies grow by 2 cycles. Use this for asynchronous/external sources.
- Not defined: inputs are sampled directly, for a same-clock source only.

## Structure
- Shared package `pam_rx_pkg`:
  - FSM state encoding (IDLE, SHIFT, DONE, WAIT_HIGH).
  - Default `DATA_LENGTH`/`TIMEOUT_CLKS` constants.
- Sub-module `pam_rx_edge`:
  - Optional synchronizer (macro-controlled), delayed copies, and fall/rise strobes for `bclk` and `nsync`.
  - Also outputs synchronized `sdata`.

## Test plan
- Source at 12 `clk` per `bclk`, frame 0xA5C3F0 → `data`=0xA5C3F0, `valid` for 1 cycle at nsync-rise+1, `frame_err`=0.
- Preload good word 0x123456, then a 23-bit frame → `frame_err` for 1 cycle, `data` stays 0x123456. Then a 25-bit frame → `frame_err`, `data` unchanged.
- `nsync` low after 5 bits, `bclk` held for 64 `clk` → `frame_err` at cycle 65 after the last fall, FSM in WAIT_HIGH until `nsync`=1, then the next good frame is accepted.
- Reset asserted after bit 10 of a frame, released, remaining 14 bits sent → no `valid`/`frame_err`. The next frame 0x000001 gives `data`=0x000001.
- Two back-to-back frames 0xFFFFFF and 0x000000 with 1-cycle `nsync` high → two `valid` pulses with correct words.
- `enable` dropped mid-frame then restored → no strobes. The next full frame is decoded.
